// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared helpers and defaults for the CPU output-capture block
package cpu_io_pkg;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r++;
    return r;
  endfunction
  function automatic int ch_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction
  localparam logic [19:0] DEF_CH_BASE = 20'hFFFF0;
  localparam int DEF_LOG_W = ch_width(4) + 16;
endpackage

// File: rtl/cpu_io_capture_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO; a push into a full FIFO lands only when a pop frees a slot
module sync_fifo
  import cpu_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_cnt;
  logic w_wr, w_rd;
  assign empty = r_cnt == '0;
  assign full  = r_cnt == (AW+1)'(DEPTH);
  assign w_rd  = pop && !empty;
  assign w_wr  = push && (!full || w_rd);
  assign dout  = r_mem[r_rptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wptr] <= din;
endmodule

// File: rtl/cpu_io_capture.sv
// cpu_io_capture: snoops CPU stores into per-channel registers, logs them, counts cycles to halt
// Define CPU_IO_CAPTURE_ALL_EN to fold out-of-window stores into channel 0 (legacy last-store mode).
module cpu_io_capture
  import cpu_io_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 20,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    NUM_CH     = 4,
  parameter logic [ADDR_WIDTH-1:0] CH_BASE    = ADDR_WIDTH'(DEF_CH_BASE),
  parameter int                    FIFO_DEPTH = 8,
  parameter int                    CNT_WIDTH  = 32,
  localparam int                   CH_W       = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_WIDTH-1:0]        bus_addr,
  input  logic [DATA_WIDTH-1:0]        bus_data,
  input  logic                         mem_write,
  input  logic                         halted,
  output logic [NUM_CH*DATA_WIDTH-1:0] solution,
  output logic [NUM_CH-1:0]            sol_valid,
  output logic [DATA_WIDTH-1:0]        log_data,
  output logic [CH_W-1:0]              log_ch,
  output logic                         log_valid,
  input  logic                         log_ready,
  output logic                         log_overflow,
  output logic [CNT_WIDTH-1:0]         cycles,
  output logic                         done
);
  localparam int LOG_W = CH_W + DATA_WIDTH;
  logic [ADDR_WIDTH-1:0] w_off;
  logic w_hit, w_cap, w_pop, w_full, w_empty;
  logic [CH_W-1:0] w_ch;
  logic [LOG_W-1:0] w_dout;
  logic [NUM_CH*DATA_WIDTH-1:0] r_sol;
  logic [NUM_CH-1:0] r_vld;
  logic r_ovf, r_done;
  logic [CNT_WIDTH-1:0] r_cyc;
  assign w_off = bus_addr - CH_BASE;
  assign w_hit = mem_write && !r_done && bus_addr >= CH_BASE && w_off < ADDR_WIDTH'(NUM_CH);
`ifdef CPU_IO_CAPTURE_ALL_EN
  assign w_cap = mem_write && !r_done;
  assign w_ch  = w_hit ? w_off[CH_W-1:0] : '0;
`else
  assign w_cap = w_hit;
  assign w_ch  = w_off[CH_W-1:0];
`endif
  assign w_pop = !w_empty && log_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_sol  <= '0;
      r_vld  <= '0;
      r_ovf  <= 1'b0;
      r_cyc  <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_cap) begin
        r_sol[w_ch*DATA_WIDTH +: DATA_WIDTH] <= bus_data;
        r_vld[w_ch] <= 1'b1;
      end
      if (w_cap && w_full && !w_pop) r_ovf <= 1'b1;
      if (!r_done) begin
        if (r_cyc != '1) r_cyc <= r_cyc + 1'b1;
        if (halted) r_done <= 1'b1;
      end
    end
  sync_fifo #(.WIDTH(LOG_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_cap),
    .din   ({w_ch, bus_data}),
    .pop   (w_pop),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full)
  );
  assign {log_ch, log_data} = w_dout;
  assign log_valid    = !w_empty;
  assign solution     = r_sol;
  assign sol_valid    = r_vld;
  assign log_overflow = r_ovf;
  assign cycles       = r_cyc;
  assign done         = r_done;
endmodule

// File: tb/tb_cpu_io_capture.sv
// tb_cpu_io_capture: directed plus random stores checked against a queue-based reference model
module tb_cpu_io_capture;
  localparam int AW = 20, DW = 16, NCH = 4, DEPTH = 8, CW = 32;
  localparam logic [AW-1:0] BASE = 20'hFFFF0;
  logic clk, reset, mem_write, halted, log_ready;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_data, log_data;
  logic [NCH*DW-1:0] solution;
  logic [NCH-1:0] sol_valid;
  logic [1:0] log_ch;
  logic log_valid, log_overflow, done;
  logic [CW-1:0] cycles;
  int checks = 0, failures = 0;
  logic [DW-1:0] m_sol [NCH];
  logic [NCH-1:0] m_vld;
  logic m_ovf, m_done;
  logic [CW-1:0] m_cyc;
  logic [DW+1:0] m_q [$];

  cpu_io_capture #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_BASE(BASE),
                   .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_data(bus_data),
    .mem_write(mem_write), .halted(halted), .solution(solution), .sol_valid(sol_valid),
    .log_data(log_data), .log_ch(log_ch), .log_valid(log_valid), .log_ready(log_ready),
    .log_overflow(log_overflow), .cycles(cycles), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCH*DW-1:0] es;
    for (int k = 0; k < NCH; k++) es[k*DW +: DW] = m_sol[k];
    check({tag, ".solution"}, solution, es);
    check({tag, ".sol_valid"}, sol_valid, m_vld);
    check({tag, ".log_valid"}, log_valid, m_q.size() > 0);
    check({tag, ".overflow"}, log_overflow, m_ovf);
    check({tag, ".cycles"}, cycles, m_cyc);
    check({tag, ".done"}, done, m_done);
    if (m_q.size() > 0) begin
      check({tag, ".log_data"}, log_data, m_q[0][DW-1:0]);
      check({tag, ".log_ch"}, log_ch, m_q[0][DW+1:DW]);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) m_sol[k] = '0;
    m_vld = '0; m_ovf = 0; m_done = 0; m_cyc = '0;
    m_q.delete();
  endtask

  task automatic do_reset();
    reset = 1; mem_write = 0; halted = 0; log_ready = 0; bus_addr = '0; bus_data = '0;
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    check_all("reset");
  endtask

  task automatic step(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                      input logic h, input logic rdy, input string tag);
    bit hit, cap, pop, full;
    logic [AW-1:0] off;
    logic [1:0] ch;
    bus_addr = a; bus_data = d; mem_write = we; halted = h; log_ready = rdy;
    off = a - BASE;
    hit = we && !m_done && a >= BASE && off < NCH;
`ifdef CPU_IO_CAPTURE_ALL_EN
    cap = we && !m_done;
    ch = hit ? off[1:0] : 2'd0;
`else
    cap = hit;
    ch = off[1:0];
`endif
    pop = m_q.size() > 0 && rdy;
    full = m_q.size() == DEPTH;
    if (cap) begin
      m_sol[ch] = d;
      m_vld[ch] = 1'b1;
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      if (full && !pop) m_ovf = 1'b1;
      else m_q.push_back({ch, d});
    end
    if (!m_done) begin
      if (m_cyc != '1) m_cyc++;
      if (h) m_done = 1'b1;
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1; mem_write = 0; halted = 0; log_ready = 0; bus_addr = '0; bus_data = '0;
    #12;
    do_reset();
    step(BASE + 2, 16'h1234, 1, 0, 0, "first");
    check("first.sol2", solution[47:32], 16'h1234);
    check("first.vld", sol_valid, 4'b0100);
    check("first.lch", log_ch, 2'd2);
    check("first.ldata", log_data, 16'h1234);

    do_reset();
    for (int i = 1; i <= 9; i++) step(BASE + 1, 16'(i), 1, 0, 0, "fill9");
    check("ovf.flag", log_overflow, 1'b1);
    check("ovf.ch1", solution[31:16], 16'd9);
    for (int i = 1; i <= 8; i++) begin
      check("drain.order", log_data, 64'(i));
      step('0, '0, 0, 0, 1, "drain");
    end
    check("drain.empty", log_valid, 1'b0);

    do_reset();
    for (int i = 1; i <= 8; i++) step(BASE, 16'hA0 + 16'(i), 1, 0, 0, "fill8");
    step(BASE + 3, 16'hBEEF, 1, 0, 1, "fullpp");
    check("fullpp.noovf", log_overflow, 1'b0);
    check("fullpp.head", log_data, 16'hA2);
    for (int i = 0; i < 7; i++) step('0, '0, 0, 0, 1, "tail");
    check("tail.data", log_data, 16'hBEEF);
    check("tail.ch", log_ch, 2'd3);

    do_reset();
    step(BASE + 7, 16'h5555, 1, 0, 1, "oow");
    step(BASE - 1, 16'h6666, 1, 0, 0, "oow2");
`ifdef CPU_IO_CAPTURE_ALL_EN
    check("oow.sol0", solution[15:0], 16'h6666);
    check("oow.ch", log_ch, 2'd0);
`else
    check("oow.sol", solution, 64'd0);
    check("oow.lv", log_valid, 1'b0);
`endif

    do_reset();
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) == 0) ? AW'($urandom) : BASE + AW'($urandom_range(0, 5)),
           DW'($urandom), 1'($urandom), 0, 1'($urandom), "rand");

    do_reset();
    for (int i = 0; i < 99; i++)
      step(BASE + AW'($urandom_range(0, 3)), DW'($urandom), 1'($urandom), 0, 1, "pre");
    check("pre.cycles", cycles, 32'd99);
    step(BASE, 16'hCAFE, 1, 1, 0, "halt");
    check("halt.cycles", cycles, 32'd100);
    check("halt.done", done, 1'b1);
    check("halt.sol0", solution[15:0], 16'hCAFE);
    for (int i = 0; i < 12; i++) step(BASE + 1, 16'hDEAD, 1, 0, 1, "post");
    check("post.frozen", cycles, 32'd100);
    check("post.lv", log_valid, 1'b0);

    do_reset();
    for (int i = 0; i < 4; i++) step(BASE + AW'(i), 16'h10 + 16'(i), 1, 0, 0, "q4");
    step('0, '0, 0, 0, 1, "mid");
    #2 reset = 1;
    #1;
    check("areset.lv", log_valid, 1'b0);
    check("areset.sol", solution, 64'd0);
    check("areset.vld", sol_valid, 4'd0);
    check("areset.cyc", cycles, 32'd0);
    model_reset();
    @(posedge clk); #1;
    reset = 0;
    check_all("areset");
    step(BASE + 1, 16'h7777, 1, 0, 0, "after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_io_capture.md
Name: cpu_io_capture

Overview:
- Parametrised successor to the single solution register in the CPU top level.
- Snoops the CPU data bus and captures stores to a window of NUM_CH consecutive memory-mapped output addresses into per-channel registers.
- Logs every captured store into a FIFO with a valid/ready drain port, for testbench or UART consumption.
- Counts cycles from reset to halt.
- Instantiated beside cpu, fed from cpu's bus_addr, bus_data, mem_write and halted.

Parameters:
- ADDR_WIDTH, 20: bus address width.
- DATA_WIDTH, 16: bus data width.
- NUM_CH, 4: number of output channels (1..16).
- CH_BASE, 20'hFFFF0: address of channel 0; channel k is at CH_BASE+k.
- FIFO_DEPTH, 8: log FIFO entries (power of two, >=2).
- CNT_WIDTH, 32: cycle counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- bus_addr  in  ADDR_WIDTH  CPU bus address
- bus_data  in  DATA_WIDTH  CPU bus data (sampled only when mem_write=1)
- mem_write  in  1  CPU store strobe, stage-aligned
- halted  in  1  CPU halt indication
- solution  out  NUM_CH*DATA_WIDTH  channel registers; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
- sol_valid  out  NUM_CH  per-channel written-at-least-once flag
- log_data  out  DATA_WIDTH  FIFO head data
- log_ch  out  clog2(NUM_CH) (min 1)  FIFO head channel index
- log_valid  out  1  FIFO not empty
- log_ready  in  1  consumer accepts head
- log_overflow  out  1  sticky: a store was dropped
- cycles  out  CNT_WIDTH  cycles elapsed since reset, frozen at halt
- done  out  1  halt latched

Behaviour:
- Reset (async, active-high), all outputs 0: solution, sol_valid, log_overflow, cycles, done; FIFO empty, so log_valid=0. Reset mid-operation discards FIFO contents and pending state immediately.
- Hit: mem_write=1 && done=0 && CH_BASE <= bus_addr < CH_BASE+NUM_CH. Channel index = bus_addr - CH_BASE, truncated to the log_ch width.
- On a hit at edge t:
  - solution[ch] <= bus_data and sol_valid[ch] <= 1, visible after edge t (1-cycle latency).
  - A push of {ch, bus_data} is attempted the same edge.
- Non-hit stores are ignored (but see Optional Feature).
- FIFO is first-word-fall-through:
  - log_data/log_ch reflect the head whenever log_valid=1.
  - Pop occurs when log_valid && log_ready at an edge.
  - Order is strictly store order.
- Full, push without pop: entry dropped; log_overflow <= 1 (sticky until reset); channel register still updates.
- Full, push with simultaneous pop: both happen; occupancy unchanged; no overflow.
- Empty, push with log_ready=1: no pop that cycle. The entry appears at log_valid the cycle after the push edge.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counter is clog2(FIFO_DEPTH)+1 bits.
- cycles increments by 1 every edge while done=0. It saturates at all-ones and never wraps.
- done <= 1 on the first edge where halted=1; it remains 1 until reset.
  - The cycles increment on that same edge still occurs.
  - From the next cycle, cycles is frozen and hits are suppressed.
  - A store coincident with the halt edge is still captured.
- FIFO draining continues after done.

Optional Feature:
- Macro: CPU_IO_CAPTURE_ALL_EN.
- Defined (legacy-compatible mode): any store with done=0 that misses the window is captured into channel 0 exactly like a hit, including the FIFO push with log_ch=0. This reproduces the original single-register "last store" behaviour.
- Undefined: out-of-window stores are ignored entirely.

Decomposition:
- Shared package cpu_io_pkg:
  - clog2 helper function.
  - Default CH_BASE localparam.
  - Log entry width localparam (CH_W + DATA_WIDTH).
- One sub-module: sync_fifo.
  - Parameters: WIDTH, DEPTH.
  - Signals: clk, reset, push, din, pop, dout, empty, full.
  - FWFT behaviour; simultaneous push/pop when full is allowed.
- Address decode, channel registers, cycle counter and halt latch stay in cpu_io_capture.

Test Plan:
- Reset then store 16'h1234 to CH_BASE+2 -> next cycle solution[2]=16'h1234, sol_valid=4'b0100; log_valid=1, log_ch=2, log_data=16'h1234.
- log_ready=0; 9 stores to CH_BASE+1, data 1..9, FIFO_DEPTH=8 -> log_overflow=1; channel 1 reads 9; drain yields 1..8 in order; log_valid then 0.
- FIFO full; store plus log_ready=1 in the same cycle -> no overflow; head advances; new tail holds the new data.
- Store to CH_BASE+7 (NUM_CH=4): macro off -> no state change, log_valid stays 0; macro on -> solution[0] updates and log_ch=0.
- Raise halted at cycle 100 with a coincident store -> store captured; cycles=100 at the done edge and frozen thereafter; done=1; later stores ignored.
- Assert reset mid-drain with 3 entries queued -> outputs zero asynchronously; log_valid=0 before the next clock edge.
